// File: rtl/instr_seq.sv
// instr_seq -- instruction sequencer feeding alu_mod.
//
// Holds the program counter and fetches one word per instruction from a
// synchronous instruction memory. It decodes the word into the ALU operand,
// choice and stack-control fields, then presents the result with a
// valid/stall handshake. A downstream jump request is honoured only on the
// accept cycle. Each instruction takes three cycles:
// FETCH -> DECODE -> ISSUE. The HALT_OP opcode parks the sequencer in HALT
// until reset.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   imem_rd           memory read strobe (FETCH only)
//   imem_addr         memory address, always shows pc
//   imem_data         instruction word, valid the cycle after imem_rd
//   stall             downstream not ready; hold the current issue
//   jmp, jmp_addr     jump request and target, used only on accept
//   op_code .. pop    decoded instruction fields (push/pop gated to ISSUE)
//   instr_addr        address of the issued instruction
//   issue_valid       decoded fields valid (ISSUE)
//   halted            HALT_OP reached
module instr_seq #(
  parameter int                WIDTH   = 8,
  parameter int                IWIDTH  = 8,
  parameter int                AWIDTH  = 6,
  parameter logic [IWIDTH-1:0] HALT_OP = 8'hFF
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_rd,
  output logic [AWIDTH-1:0]             imem_addr,
  input  logic [IWIDTH+3*WIDTH+8-1:0]   imem_data,
  input  logic                          stall,
  input  logic                          jmp,
  input  logic [AWIDTH-1:0]             jmp_addr,
  output logic [IWIDTH-1:0]             op_code,
  output logic [WIDTH-1:0]              source1,
  output logic [WIDTH-1:0]              source2,
  output logic [1:0]                    source1_choice,
  output logic [1:0]                    source2_choice,
  output logic [WIDTH-1:0]              destination,
  output logic [1:0]                    dest_choice,
  output logic                          push,
  output logic                          pop,
  output logic [AWIDTH-1:0]             instr_addr,
  output logic                          issue_valid,
  output logic                          halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    ISSUE  = 2'd2,
    HALT   = 2'd3
  } state_t;

  // Field slices of the incoming instruction word (MSB first).
  logic [IWIDTH-1:0] w_op;
  logic [WIDTH-1:0]  w_src1;
  logic [WIDTH-1:0]  w_src2;
  logic [WIDTH-1:0]  w_dst;
  logic [1:0]        w_c1;
  logic [1:0]        w_c2;
  logic [1:0]        w_cd;
  logic              w_push;
  logic              w_pop;

  assign w_op   = imem_data[IWIDTH+3*WIDTH+7 -: IWIDTH];
  assign w_src1 = imem_data[3*WIDTH+7 -: WIDTH];
  assign w_src2 = imem_data[2*WIDTH+7 -: WIDTH];
  assign w_dst  = imem_data[WIDTH+7 -: WIDTH];
  assign w_c1   = imem_data[7:6];
  assign w_c2   = imem_data[5:4];
  assign w_cd   = imem_data[3:2];
  assign w_push = imem_data[1];
  assign w_pop  = imem_data[0];

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] iaddr_q, iaddr_d;
  logic [IWIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0]  src1_q, src1_d;
  logic [WIDTH-1:0]  src2_q, src2_d;
  logic [WIDTH-1:0]  dst_q, dst_d;
  logic [1:0]        c1_q, c1_d;
  logic [1:0]        c2_q, c2_d;
  logic [1:0]        cd_q, cd_d;
  logic              push_q, push_d;
  logic              pop_q, pop_d;
  logic              fetch_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= '0;
      iaddr_q <= '0;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      dst_q   <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      cd_q    <= '0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iaddr_q <= iaddr_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      dst_q   <= dst_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      cd_q    <= cd_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    iaddr_d     = iaddr_q;
    op_d        = op_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    dst_d       = dst_q;
    c1_d        = c1_q;
    c2_d        = c2_q;
    cd_d        = cd_q;
    push_d      = push_q;
    pop_d       = pop_q;
    fetch_rd    = 1'b0;
    issue_valid = 1'b0;
    halted      = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;

    case (state_q)
      FETCH: begin
        fetch_rd = 1'b1;
        state_d  = DECODE;
      end
      DECODE: begin
        if (w_op == HALT_OP) begin
          // The halt word is never issued. halted rises as soon as it is
          // seen, so the output registers keep the last issued instruction.
          halted  = 1'b1;
          state_d = HALT;
        end else begin
          op_d    = w_op;
          src1_d  = w_src1;
          src2_d  = w_src2;
          dst_d   = w_dst;
          c1_d    = w_c1;
          c2_d    = w_c2;
          cd_d    = w_cd;
          push_d  = w_push;
          pop_d   = w_pop;
          iaddr_d = pc_q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issue_valid = 1'b1;
        push        = push_q;
        pop         = pop_q;
        // A jump is looked at only on the accept cycle. The pc wraps
        // naturally at 2^AWIDTH.
        if (!stall) begin
          pc_d    = jmp ? jmp_addr : pc_q + AWIDTH'(1);
          state_d = FETCH;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // The state register already sits in FETCH while reset is held. The read
  // strobe is masked by rst so that every output reads 0 during reset.
  assign imem_rd        = fetch_rd & ~rst;
  assign imem_addr      = pc_q;
  assign instr_addr     = iaddr_q;
  assign op_code        = op_q;
  assign source1        = src1_q;
  assign source2        = src2_q;
  assign destination    = dst_q;
  assign source1_choice = c1_q;
  assign source2_choice = c2_q;
  assign dest_choice    = cd_q;

endmodule

// File: tb/tb_instr_seq.sv
// Directed testbench for instr_seq: reset values, run-to-halt, field decode,
// stall hold, jump, pc wrap and reset during a stalled issue.
module tb_instr_seq;
  localparam int WIDTH  = 8;
  localparam int IWIDTH = 8;
  localparam int AWIDTH = 6;
  localparam int DW     = IWIDTH + 3*WIDTH + 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_rd;
  logic [AWIDTH-1:0] imem_addr;
  logic [DW-1:0]     imem_data = '0;
  logic              stall = 1'b0;
  logic              jmp = 1'b0;
  logic [AWIDTH-1:0] jmp_addr = '0;
  logic [IWIDTH-1:0] op_code;
  logic [WIDTH-1:0]  source1, source2, destination;
  logic [1:0]        source1_choice, source2_choice, dest_choice;
  logic              push, pop;
  logic [AWIDTH-1:0] instr_addr;
  logic              issue_valid, halted;

  logic [DW-1:0] mem [0:63];

  int total = 0;
  int bad   = 0;

  instr_seq #(
    .WIDTH(WIDTH), .IWIDTH(IWIDTH), .AWIDTH(AWIDTH), .HALT_OP(8'hFF)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .jmp(jmp), .jmp_addr(jmp_addr),
    .op_code(op_code), .source1(source1), .source2(source2),
    .source1_choice(source1_choice), .source2_choice(source2_choice),
    .destination(destination), .dest_choice(dest_choice),
    .push(push), .pop(pop), .instr_addr(instr_addr),
    .issue_valid(issue_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data appears the cycle after imem_rd.
  always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

  function automatic logic [DW-1:0] mk(input logic [7:0] op, input logic [7:0] s1,
                                       input logic [7:0] s2, input logic [7:0] d,
                                       input logic [1:0] c1, input logic [1:0] c2,
                                       input logic [1:0] cd, input logic pu, input logic po);
    return {op, s1, s2, d, c1, c2, cd, pu, po};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Each cycle: inputs driven at posedge+1, outputs sampled at negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; stall = 1'b0; jmp = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".imem_rd"},   imem_rd, 0);
    check_eq({tag, ".imem_addr"}, imem_addr, 0);
    check_eq({tag, ".op_code"},   op_code, 0);
    check_eq({tag, ".source1"},   source1, 0);
    check_eq({tag, ".source2"},   source2, 0);
    check_eq({tag, ".dest"},      destination, 0);
    check_eq({tag, ".choices"},   {source1_choice, source2_choice, dest_choice}, 0);
    check_eq({tag, ".push_pop"},  {push, pop}, 0);
    check_eq({tag, ".instr_addr"}, instr_addr, 0);
    check_eq({tag, ".issue_valid"}, issue_valid, 0);
    check_eq({tag, ".halted"},    halted, 0);
  endtask

  initial begin
    // ---- Reset then run to HALT ----
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = mk(8'h01, 8'h10, 8'h20, 8'h30, 2'd1, 2'd2, 2'd3, 1'b0, 1'b1);
    mem[1] = mk(8'h02, 8'h44, 8'h55, 8'h66, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0);
    mem[2] = {8'hFF, 32'h0};
    rst = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_all_zero("reset");
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_eq($sformatf("run.issue_valid[%0d]", c), issue_valid, (c == 2 || c == 5));
      check_eq($sformatf("run.imem_rd[%0d]", c), imem_rd, (c == 0 || c == 3 || c == 6));
      check_eq($sformatf("run.halted[%0d]", c), halted, (c >= 7));
      check_eq($sformatf("run.imem_addr[%0d]", c), imem_addr, (c < 3) ? 0 : (c < 6) ? 1 : 2);
      if (issue_valid) $display("issue cycle=%0d addr=%0d op=%0h", c, instr_addr, op_code);
      if (c == 2) begin
        check_eq("run.addr0", instr_addr, 0);
        check_eq("run.op0", op_code, 8'h01);
        check_eq("run.pushpop0", {push, pop}, 2'b01);
      end
      if (c == 5) begin
        check_eq("run.addr1", instr_addr, 1);
        check_eq("run.op1", op_code, 8'h02);
        check_eq("run.pushpop1", {push, pop}, 2'b10);
      end
      if (c >= 7) check_eq($sformatf("run.hold_op[%0d]", c), op_code, 8'h02);
      next_cycle();
    end

    // ---- Field decode (reset also leaves HALT) ----
    mem[0] = 40'h11_AA_BB_CC_B6;
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    check_eq("halt_reset.halted", halted, 0);
    check_eq("halt_reset.op_code", op_code, 0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("dec.issue_valid", issue_valid, 1);
    check_eq("dec.op_code", op_code, 8'h11);
    check_eq("dec.source1", source1, 8'hAA);
    check_eq("dec.source2", source2, 8'hBB);
    check_eq("dec.dest", destination, 8'hCC);
    check_eq("dec.c1", source1_choice, 2);
    check_eq("dec.c2", source2_choice, 3);
    check_eq("dec.cd", dest_choice, 1);
    check_eq("dec.push", push, 1);
    check_eq("dec.pop", pop, 0);
    $display("decode op=%0h s1=%0h s2=%0h d=%0h", op_code, source1, source2, destination);

    // ---- Stall hold, with a jump that coincides with stall ----
    mem[0] = mk(8'h21, 8'h01, 8'h02, 8'h03, 2'd1, 2'd1, 2'd1, 1'b1, 1'b0);
    mem[1] = mk(8'h22, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    reset_dut();
    next_cycle();
    next_cycle();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      jmp = (k == 1);
      jmp_addr = 6'd33;
      @(negedge clk);
      check_eq($sformatf("stall.iv[%0d]", k), issue_valid, 1);
      check_eq($sformatf("stall.addr[%0d]", k), instr_addr, 0);
      check_eq($sformatf("stall.op[%0d]", k), op_code, 8'h21);
      check_eq($sformatf("stall.push[%0d]", k), push, 1);
      check_eq($sformatf("stall.pc[%0d]", k), imem_addr, 0);
      check_eq($sformatf("stall.rd[%0d]", k), imem_rd, 0);
      next_cycle();
    end
    stall = 1'b0;
    jmp = 1'b0;
    @(negedge clk);
    check_eq("stall.accept_iv", issue_valid, 1);
    next_cycle();
    @(negedge clk);
    check_eq("stall.next_rd", imem_rd, 1);
    check_eq("stall.next_addr", imem_addr, 1);
    check_eq("stall.iv_fall", issue_valid, 0);
    $display("stall released, next fetch addr=%0d", imem_addr);

    // ---- Jump (and ignored jump in DECODE) ----
    for (int i = 0; i < 64; i++)
      mem[i] = mk(8'h05, 8'h5A, 8'hA5, 8'h3C, 2'd3, 2'd3, 2'd3, 1'b1, 1'b1);
    reset_dut();
    for (int i = 0; i < 4; i++) next_cycle();
    jmp = 1'b1;
    jmp_addr = 6'd50;
    next_cycle();
    jmp = 1'b0;
    @(negedge clk);
    check_eq("jmp.iv1", issue_valid, 1);
    check_eq("jmp.addr1", instr_addr, 1);
    next_cycle();
    @(negedge clk);
    check_eq("jmp.decode_ignored", imem_addr, 2);
    check_eq("jmp.rd2", imem_rd, 1);
    for (int i = 0; i < 5; i++) next_cycle();
    jmp = 1'b1;
    jmp_addr = 6'd40;
    @(negedge clk);
    check_eq("jmp.addr3", instr_addr, 3);
    check_eq("jmp.iv3", issue_valid, 1);
    next_cycle();
    jmp = 1'b0;
    @(negedge clk);
    check_eq("jmp.target_rd", imem_rd, 1);
    check_eq("jmp.target_addr", imem_addr, 40);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("jmp.issue40", instr_addr, 40);
    $display("jump taken to addr=%0d", instr_addr);

    // ---- pc wrap 63 -> 0 ----
    reset_dut();
    for (int i = 0; i < 191; i++) next_cycle();
    @(negedge clk);
    check_eq("wrap.iv63", issue_valid, 1);
    check_eq("wrap.addr63", instr_addr, 63);
    next_cycle();
    @(negedge clk);
    check_eq("wrap.rd0", imem_rd, 1);
    check_eq("wrap.addr0", imem_addr, 0);
    $display("wrap fetch addr=%0d", imem_addr);

    // ---- Reset during a stalled issue ----
    for (int i = 0; i < 5; i++) next_cycle();
    stall = 1'b1;
    @(negedge clk);
    check_eq("midrst.iv", issue_valid, 1);
    check_eq("midrst.addr", instr_addr, 1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst.iv_hold", issue_valid, 1);
    check_eq("midrst.pushpop", {push, pop}, 2'b11);
    next_cycle();
    @(negedge clk);
    check_all_zero("midrst");
    next_cycle();
    rst = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check_eq("midrst.fetch_rd", imem_rd, 1);
    check_eq("midrst.fetch_addr", imem_addr, 0);
    check_eq("midrst.fetch_iv", issue_valid, 0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("midrst.reissue_addr", instr_addr, 0);
    check_eq("midrst.reissue_s1", source1, 8'h5A);
    $display("post-reset issue addr=%0d", instr_addr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_seq.md
# instr_seq

Instruction sequencer that sits directly upstream of `alu_mod`. It holds the program counter, fetches one instruction word per instruction from a synchronous instruction memory, and decodes it into the ALU's operand, choice and stack-control fields. It presents each decoded instruction to the ALU with a valid/stall handshake, and accepts a jump request from downstream.

## Interface
Parameters:
- `WIDTH`, 8, data and operand field width
- `IWIDTH`, 8, opcode width
- `AWIDTH`, 6, instruction address width (program length 2^AWIDTH)
- `HALT_OP`, 8'hFF, opcode that stops sequencing

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous active-high reset
- `imem_rd`  out  1  instruction memory read strobe
- `imem_addr`  out  AWIDTH  instruction memory address
- `imem_data`  in  IWIDTH+3*WIDTH+8  instruction word, valid the cycle after `imem_rd`
- `stall`  in  1  downstream not ready; hold the current issue
- `jmp`  in  1  take jump; sampled only on accept
- `jmp_addr`  in  AWIDTH  jump target
- `op_code`  out  IWIDTH  decoded opcode
- `source1`, `source2`  out  WIDTH  operand fields
- `source1_choice`, `source2_choice`  out  2  operand source selects
- `destination`  out  WIDTH  destination field
- `dest_choice`  out  2  destination select
- `push`, `pop`  out  1  stack controls; 0 outside ISSUE
- `instr_addr`  out  AWIDTH  address of the issued instruction
- `issue_valid`  out  1  decoded fields valid
- `halted`  out  1  HALT_OP reached

## Operation
- Instruction word layout, MSB first: `op_code`[39:32], `source1`[31:24], `source2`[23:16], `destination`[15:8], `source1_choice`[7:6], `source2_choice`[5:4], `dest_choice`[3:2], `push`[1], `pop`[0].
- FSM states: FETCH, DECODE, ISSUE, HALT.
  - FETCH: `imem_rd`=1 and `imem_addr`=pc. Next state is DECODE.
  - DECODE: sample `imem_data`.
    - If opcode == HALT_OP, go to HALT. Output registers are unchanged.
    - Otherwise, register all fields and set `instr_addr`=pc. Next state is ISSUE.
  - ISSUE: `issue_valid`=1. `push`/`pop` equal the decoded bits.
    - Accept = ISSUE && !`stall`.
    - On accept: pc ← `jmp` ? `jmp_addr` : pc+1, then go to FETCH.
    - While `stall`=1, all outputs are held stable.
  - HALT: `halted`=1, `issue_valid`=0, `imem_rd`=0. Only `rst` leaves this state.
- pc increments modulo 2^AWIDTH; 63+1 wraps to 0. A jump to the current address is legal.
- `jmp` outside an accept cycle is ignored.
- `imem_rd` is 0 in every state except FETCH. `imem_addr` shows pc in all states.

## Timing
- Reset values: pc=0, state=FETCH in the cycle after `rst`, and every output 0. This includes `imem_addr`, all decoded fields, `instr_addr`, `issue_valid`, `halted`, `push` and `pop`.
- Reset mid-operation, in any state including ISSUE with `stall` high or HALT: the cycle after `rst` deasserts is FETCH at address 0. No partial issue survives.
- Latency: `imem_rd` in cycle n, then `issue_valid` high from cycle n+2. With no stall, throughput is one instruction per 3 cycles.
- `issue_valid` falls in the cycle after accept. Each instruction is accepted exactly once.
- `stall` and `jmp` asserted in the same cycle: no accept, and the jump is ignored. Keep `jmp` until the accept cycle.
- HALT_OP is never issued. `instr_addr` keeps the last issued address.

## Test plan
- Reset then run: program {0: 8'h01 word, 1: 8'h02 word, 2: HALT_OP}, `stall`=0.
  - `issue_valid` pulses at cycles 2 and 5 with `instr_addr` 0 and 1.
  - `halted`=1 from cycle 7, and `imem_rd` stays 0 afterwards.
- Field decode: word 40'h11_AA_BB_CC_B6.
  - Expect `op_code`=11, `source1`=AA, `source2`=BB, `destination`=CC.
  - Expect choices 2/3/1, `push`=1, `pop`=0.
- Stall: hold `stall`=1 for 4 cycles during ISSUE.
  - Outputs stay stable and pc does not change.
  - The next `imem_rd` comes 1 cycle after `stall` drops.
- Jump: `jmp`=1 with `jmp_addr`=6'd40 at the accept of address 3 → next `imem_addr`=40.
  - A `jmp` pulse in DECODE has no effect.
- Wrap: fill memory with NOPs → after address 63 is issued, the next fetch is address 0.
- Reset mid-run: assert `rst` during ISSUE with `stall`=1 → all outputs are 0 in the next cycle, then FETCH at address 0.
